// File: rtl/sprite_pkg.sv
// Shared constants, fetch state encoding and small helpers for the sprite line fetcher.
// Geometry matches the indexed sprite sheet: 2441 x 130 pixels, 4-bit colour indices.
package sprite_pkg;

    localparam int SHEET_W = 2441;
    localparam int SHEET_H = 130;
    localparam int MAX_W   = 128;
    localparam int ADDR_W  = 19;

    localparam int COL_W = $clog2(MAX_W);
    localparam int WID_W = COL_W + 1;

    localparam logic [3:0] TRANSPARENT = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BASE,
        ST_ISSUE,
        ST_DRAIN
    } fetch_state_e;

    function automatic logic [WID_W-1:0] clamp_width(input logic [7:0] width);
        return (width > 8'(MAX_W)) ? WID_W'(MAX_W) : WID_W'(width);
    endfunction

    // True when sheet column x+k falls past the right edge of the sheet.
    function automatic logic col_x_oob(input logic [11:0] x, input logic [COL_W-1:0] k);
        logic [12:0] sum;
        sum = {1'b0, x} + {6'b0, k};
        return sum >= 13'(SHEET_W);
    endfunction

endpackage

// File: rtl/line_buffer_bank.sv
// One bank of the ping-pong line buffer: synchronous write port, registered read port.
// The parent selects which bank is front (read) and which is back (written).
module line_buffer_bank
    import sprite_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             wr_en,
    input  logic [COL_W-1:0] wr_addr,
    input  logic [3:0]       wr_data,
    input  logic [COL_W-1:0] rd_addr,
    output logic [3:0]       rd_data
);

    logic [3:0] mem_q [MAX_W];
    logic [3:0] rd_data_q;
    logic [3:0] rd_data_d;

    always_comb begin
        rd_data_d = mem_q[rd_addr];
    end

    // NOTE: the storage array has no reset so it can map onto a RAM macro; stale
    // contents are harmless because the parent masks reads beyond the valid width.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sprite_line_fetcher.sv
// Fetches one sprite row from the sprite-sheet RAM into the back bank of a ping-pong
// line buffer while the renderer reads the front bank by column.
module sprite_line_fetcher
    import sprite_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [11:0]       sheet_x,
    input  logic [7:0]        sheet_y,
    input  logic [6:0]        row,
    input  logic [7:0]        width,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [3:0]        ram_data,
    input  logic              swap,
    input  logic [6:0]        pix_col,
    output logic [3:0]        pix_data
);

    fetch_state_e      state_q, state_d;
    logic [11:0]       x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [6:0]        row_q, row_d;
    logic [WID_W-1:0]  w_q, w_d;
    logic              y_oob_q, y_oob_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wr_en_q, wr_en_d;
    logic [COL_W-1:0]  wr_col_q, wr_col_d;
    logic              wr_oob_q, wr_oob_d;
    logic              front_q, front_d;
    logic              swap_pend_q, swap_pend_d;
    logic [WID_W-1:0]  front_width_q, front_width_d;
    logic [WID_W-1:0]  back_width_q, back_width_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_sel_q, rd_sel_d;

    logic [8:0]        row_sum;
    logic              y_oob_now;
    logic [ADDR_W-1:0] base_now;
    logic              col_last;
    logic [COL_W-1:0]  col_nxt;
    logic              cur_oob;
    logic              nxt_oob;

    logic [3:0]        wr_data;
    logic [3:0]        rd_data0;
    logic [3:0]        rd_data1;

    always_comb begin
        row_sum   = {1'b0, y_q} + {2'b00, row_q};
        y_oob_now = row_sum >= 9'(SHEET_H);
        base_now  = ADDR_W'(row_sum) * ADDR_W'(SHEET_W) + ADDR_W'(x_q);
        col_last  = ({1'b0, col_q} == (w_q - 8'd1));
        col_nxt   = col_q + 7'd1;
        cur_oob   = y_oob_q || col_x_oob(x_q, col_q);
        nxt_oob   = y_oob_q || col_x_oob(x_q, col_nxt);
    end

    // NOTE: every _d starts as its _q (pulses start at 0) so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        row_d         = row_q;
        w_d           = w_q;
        y_oob_d       = y_oob_q;
        base_d        = base_q;
        col_d         = col_q;
        ram_addr_d    = ram_addr_q;
        done_d        = 1'b0;
        wr_en_d       = 1'b0;
        wr_col_d      = wr_col_q;
        wr_oob_d      = wr_oob_q;
        back_width_d  = back_width_q;
        front_d       = front_q;
        swap_pend_d   = swap_pend_q;
        front_width_d = front_width_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = sheet_x;
                    y_d     = sheet_y;
                    row_d   = row;
                    w_d     = clamp_width(width);
                    state_d = ST_BASE;
                end
            end
            ST_BASE: begin
                base_d  = base_now;
                y_oob_d = y_oob_now;
                col_d   = '0;
                if (w_q == '0) begin
                    state_d      = ST_IDLE;
                    done_d       = 1'b1;
                    back_width_d = w_q;
                end else begin
                    state_d = ST_ISSUE;
                    // An off-sheet column keeps the previous address on the bus.
                    if (!y_oob_now && !col_x_oob(x_q, '0)) begin
                        ram_addr_d = base_now;
                    end
                end
            end
            ST_ISSUE: begin
                wr_en_d  = 1'b1;
                wr_col_d = col_q;
                wr_oob_d = cur_oob;
                if (col_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    col_d = col_nxt;
                    if (!nxt_oob) begin
                        ram_addr_d = base_q + ADDR_W'(col_nxt);
                    end
                end
            end
            ST_DRAIN: begin
                state_d      = ST_IDLE;
                done_d       = 1'b1;
                back_width_d = w_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);

        // Banks may only exchange while no fetch is writing the back bank.
        if (busy_q) begin
            if (swap) begin
                swap_pend_d = 1'b1;
            end
        end else if (swap || swap_pend_q) begin
            front_d       = ~front_q;
            front_width_d = back_width_q;
            swap_pend_d   = 1'b0;
        end

        rd_valid_d = ({1'b0, pix_col} < front_width_q);
        rd_sel_d   = front_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            row_q         <= '0;
            w_q           <= '0;
            y_oob_q       <= 1'b0;
            base_q        <= '0;
            col_q         <= '0;
            ram_addr_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_col_q      <= '0;
            wr_oob_q      <= 1'b0;
            front_q       <= 1'b0;
            swap_pend_q   <= 1'b0;
            front_width_q <= '0;
            back_width_q  <= '0;
            rd_valid_q    <= 1'b0;
            rd_sel_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            row_q         <= row_d;
            w_q           <= w_d;
            y_oob_q       <= y_oob_d;
            base_q        <= base_d;
            col_q         <= col_d;
            ram_addr_q    <= ram_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            wr_en_q       <= wr_en_d;
            wr_col_q      <= wr_col_d;
            wr_oob_q      <= wr_oob_d;
            front_q       <= front_d;
            swap_pend_q   <= swap_pend_d;
            front_width_q <= front_width_d;
            back_width_q  <= back_width_d;
            rd_valid_q    <= rd_valid_d;
            rd_sel_q      <= rd_sel_d;
        end
    end

    // RAM data arriving now belongs to the column presented one cycle earlier.
    assign wr_data = wr_oob_q ? TRANSPARENT : ram_data;

    line_buffer_bank u_bank0 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .wr_en   (wr_en_q & front_q),
        .wr_addr (wr_col_q),
        .wr_data (wr_data),
        .rd_addr (pix_col),
        .rd_data (rd_data0)
    );

    line_buffer_bank u_bank1 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .wr_en   (wr_en_q & ~front_q),
        .wr_addr (wr_col_q),
        .wr_data (wr_data),
        .rd_addr (pix_col),
        .rd_data (rd_data1)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign ram_addr = ram_addr_q;
    assign pix_data = rd_valid_q ? (rd_sel_q ? rd_data1 : rd_data0) : TRANSPARENT;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench for sprite_line_fetcher: a line-level reference model checked every
// cycle, plus hand-computed expectations at the cycles the timing rules pin down.
module tb_sprite_line_fetcher;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        start = 1'b0;
    logic [11:0] sheet_x = '0;
    logic [7:0]  sheet_y = '0;
    logic [6:0]  row = '0;
    logic [7:0]  width = '0;
    logic        busy;
    logic        done;
    logic [18:0] ram_addr;
    logic [3:0]  ram_data = '0;
    logic        swap = 1'b0;
    logic [6:0]  pix_col = '0;
    logic [3:0]  pix_data;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    sprite_line_fetcher dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .sheet_x  (sheet_x),
        .sheet_y  (sheet_y),
        .row      (row),
        .width    (width),
        .busy     (busy),
        .done     (done),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .swap     (swap),
        .pix_col  (pix_col),
        .pix_data (pix_data)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [3:0] mem_fn(input logic [18:0] a);
        return (a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {1'b0, a[18:16]}) + 4'd1;
    endfunction

    // Sprite-sheet RAM with one cycle of registered read latency.
    always @(posedge Clk) ram_data <= mem_fn(ram_addr);

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (line-level) ----------------
    bit          m_active;
    int          m_t;
    int          m_w;
    int          m_base;
    bit          m_inr  [128];
    logic [3:0]  m_line [128];
    logic [3:0]  m_bank [2][128];
    bit          m_front;
    bit          m_pend;
    int          m_fw;
    int          m_bw;
    logic [18:0] m_addr;
    bit          m_done;
    logic [3:0]  m_pix;

    task automatic model_reset();
        m_active = 0;
        m_t      = 0;
        m_front  = 0;
        m_pend   = 0;
        m_fw     = 0;
        m_bw     = 0;
        m_addr   = '0;
        m_done   = 0;
        m_pix    = '0;
    endtask

    task automatic model_step();
        logic [3:0] npix;
        bit         done_n;
        bit         front_old;
        int         ysum;
        npix      = (int'(pix_col) < m_fw) ? m_bank[m_front][pix_col] : 4'h0;
        done_n    = 0;
        front_old = m_front;
        if (m_active) begin
            if (swap) m_pend = 1;
        end else if (swap || m_pend) begin
            m_front = ~m_front;
            m_fw    = m_bw;
            m_pend  = 0;
        end
        if (m_active) begin
            m_t++;
            if ((m_w == 0 && m_t == 2) || (m_w > 0 && m_t == 3 + m_w)) begin
                m_active = 0;
                done_n   = 1;
                m_bw     = m_w;
                for (int k = 0; k < m_w; k++) m_bank[!front_old][k] = m_line[k];
            end else if (m_t >= 2 && m_t <= 1 + m_w) begin
                if (m_inr[m_t-2]) m_addr = 19'(m_base + m_t - 2);
            end
        end else if (start) begin
            m_active = 1;
            m_t      = 1;
            m_w      = (int'(width) > 128) ? 128 : int'(width);
            ysum     = int'(sheet_y) + int'(row);
            m_base   = (ysum * 2441 + int'(sheet_x)) % 524288;
            for (int k = 0; k < 128; k++) begin
                m_inr[k]  = (ysum < 130) && (int'(sheet_x) + k < 2441);
                m_line[k] = m_inr[k] ? mem_fn(19'(m_base + k)) : 4'h0;
            end
        end
        m_done = done_n;
        m_pix  = npix;
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < 128; k++) m_bank[b][k] = '0;
        model_reset();
        forever begin
            @(negedge Clk);
            if (!Reset_n) model_reset();
            check("busy", busy, m_active);
            check("done", done, m_done);
            check("ram_addr", ram_addr, m_addr);
            check("pix_data", pix_data, m_pix);
            @(posedge Clk);
            if (!Reset_n) model_reset();
            else model_step();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic go_to(input int c);
        while (cyc < c) @(negedge Clk);
    endtask

    task automatic fetch(input int x, input int y, input int r, input int w, output int t);
        @(negedge Clk);
        sheet_x = 12'(x);
        sheet_y = 8'(y);
        row     = 7'(r);
        width   = 8'(w);
        start   = 1'b1;
        t       = cyc;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            pix_col = 7'(i);
        end
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        int done_seen;
        Reset_n = 1'b1;
        #2 Reset_n = 1'b0;
        @(negedge Clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ram_addr", ram_addr, 0);
        check("reset_pix", pix_data, 0);
        @(posedge Clk);
        #2 Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Main fetch: row base 13*2441+100 = 31833; swap mid-fetch, start ignored.
        fetch(100, 10, 3, 16, t);
        check("A_busy_T1", busy, 1);
        go_to(t + 2);  check("A_addr_T2", ram_addr, 31833);
        go_to(t + 5);  swap = 1'b1;
        go_to(t + 6);  swap = 1'b0;
        go_to(t + 7);  start = 1'b1; sheet_x = 12'd0; width = 8'd5;
        go_to(t + 8);  start = 1'b0;
        go_to(t + 17); check("A_addr_T17", ram_addr, 31848);
        go_to(t + 18); check("A_done_T18", done, 0);
        go_to(t + 19); check("A_done_T19", done, 1); check("A_busy_T19", busy, 0); pix_col = 7'd0;
        go_to(t + 20); check("A_front_unchanged", pix_data, 0); pix_col = 7'd0;
        go_to(t + 21); check("A_pix0", pix_data, mem_fn(19'd31833)); pix_col = 7'd16;
        go_to(t + 22); check("A_pix16", pix_data, 0);
        sweep(17);

        // Width clamp: 200 -> 128 columns at addresses 0..127.
        fetch(0, 0, 0, 200, t);
        go_to(t + 129); check("B_addr_last", ram_addr, 127);
        go_to(t + 130); check("B_done_T130", done, 0);
        go_to(t + 131); check("B_done_T131", done, 1); swap = 1'b1;
        go_to(t + 132); swap = 1'b0; pix_col = 7'd127;
        go_to(t + 133); check("B_pix127", pix_data, mem_fn(19'd127));
        sweep(128);

        // Right-edge clip: columns 11..15 transparent, address held at 2440.
        fetch(2430, 0, 0, 16, t);
        go_to(t + 12); check("C_addr_col10", ram_addr, 2440);
        go_to(t + 17); check("C_addr_held", ram_addr, 2440);
        go_to(t + 19); check("C_done", done, 1); swap = 1'b1;
        go_to(t + 20); swap = 1'b0; pix_col = 7'd10;
        go_to(t + 21); check("C_pix10", pix_data, mem_fn(19'd2440)); pix_col = 7'd11;
        go_to(t + 22); check("C_pix11", pix_data, 0);
        sweep(16);

        // Height clip: every column transparent, no new address driven.
        fetch(0, 128, 5, 16, t);
        go_to(t + 10); check("D_addr_held", ram_addr, 2440);
        go_to(t + 19); check("D_done", done, 1); swap = 1'b1;
        go_to(t + 20); swap = 1'b0; pix_col = 7'd0;
        go_to(t + 21); check("D_pix0", pix_data, 0);
        sweep(16);

        // Zero width completes straight out of BASE.
        fetch(7, 0, 0, 0, t);
        check("Z_busy_T1", busy, 1);
        go_to(t + 2); check("Z_done_T2", done, 1); check("Z_busy_T2", busy, 0);
        check("Z_addr", ram_addr, 2440);
        repeat (3) @(negedge Clk);

        // Reset during a fetch: no done afterwards, all columns read transparent.
        fetch(100, 10, 3, 16, t);
        go_to(t + 7);
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        @(negedge Clk);
        check("E_busy_rst", busy, 0);
        check("E_done_rst", done, 0);
        @(posedge Clk);
        #2 Reset_n = 1'b1;
        done_seen = 0;
        repeat (25) begin
            @(negedge Clk);
            if (done) done_seen++;
        end
        check("E_no_done", done_seen, 0);
        pix_col = 7'd3;
        @(negedge Clk);
        check("E_pix_after_rst", pix_data, 0);
        sweep(128);

        // Recovery fetch after reset.
        fetch(5, 1, 0, 4, t);
        go_to(t + 7); check("F_done", done, 1); swap = 1'b1;
        go_to(t + 8); swap = 1'b0; pix_col = 7'd0;
        go_to(t + 9); check("F_pix0", pix_data, mem_fn(19'd2446));
        sweep(5);

        repeat (2) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_line_fetcher.md
# sprite_line_fetcher

Reads one horizontal row of a sprite out of the indexed sprite-sheet RAM (2441×130, 4-bit color indices, 1-cycle registered read) and buffers it for the pixel pipeline. It drives the RAM read port, absorbs its read latency, and fills the back bank of an internal ping-pong line buffer during blanking. The renderer concurrently reads the front bank by column.

## Interface
- SHEET_W, 2441, sheet width in pixels
- SHEET_H, 130, sheet height in rows
- MAX_W, 128, max sprite width (line buffer depth per bank)
- ADDR_W, 19, RAM address width
- Clk  input  1  system clock, all logic on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to fetch a row; ignored while busy
- sheet_x  input  12  sprite left column in sheet
- sheet_y  input  8  sprite top row in sheet
- row  input  7  row within sprite to fetch
- width  input  8  pixels to fetch; values >MAX_W clamp to MAX_W
- busy  output  1  fetch in progress
- done  output  1  one-cycle pulse, back bank complete
- ram_addr  output  ADDR_W  RAM read address
- ram_data  input  4  RAM read data, valid the cycle after ram_addr
- swap  input  1  one-cycle request to exchange front/back banks
- pix_col  input  7  front-bank column to read
- pix_data  output  4  front-bank color index, registered

## Operation
- Reset: state IDLE, busy=0, done=0, ram_addr=0, pix_data=0, front bank=0, swap_pending=0, front_width=0, back_width=0. Buffer contents are not reset.
- FSM: IDLE -> BASE -> ISSUE -> DRAIN -> IDLE. If the clamped width is 0, the FSM goes BASE -> IDLE.
- IDLE: on start, latch inputs and w=min(width,MAX_W). Go to BASE.
- BASE: compute base=(sheet_y+row)*SHEET_W+sheet_x in ADDR_W bits. Clear col=0.
- ISSUE: present ram_addr=base+col and increment col. Leave after col w-1 is issued.
- DRAIN: one cycle that captures the data for the last column.
- Write rule: ram_data seen in cycle k+1 is written to back[k], where k is the column presented in cycle k.
- Out of range: if sheet_y+row>=SHEET_H, or sheet_x+k>=SHEET_W, index 0 (transparent) is written for that column. ram_addr is held at its previous value for that column, so no out-of-range address is ever driven.
- Completion: back_width=w is recorded at done.
- Swap:
  - swap while not busy: banks exchange next edge, and front_width takes back_width.
  - swap while busy: sets swap_pending. The exchange happens on the edge after done.
  - swap coincident with done: treated as pending, same result.
- Read: pix_data <= (pix_col<front_width) ? front[pix_col] : 0.

## Timing
- start sampled at edge of cycle T. BASE is cycle T+1. busy is high from T+1.
- ram_addr for column k is driven in cycle T+2+k. The write for column k occurs at the end of cycle T+3+k.
- DRAIN is cycle T+2+w. done=1 and busy=0 in cycle T+3+w. A new start is accepted in that cycle.
- Width 0: done in cycle T+2, no RAM addresses driven, back_width=0.
- pix_data latency: 1 cycle from pix_col.
- A bank swap is visible on pix_data starting with the read sampled after the swap edge.
- Reset_n asserted mid-fetch: FSM returns to IDLE immediately, with no done pulse. A partially written back bank is discarded because back_width=0.

## Structure
- Shared package sprite_pkg holds:
  - SHEET_W, SHEET_H, MAX_W, ADDR_W
  - the transparent index constant TRANSPARENT=4'h0
  - the fetch state enum typedef
- Sub-module line_buffer_bank: dual-port 4-bit×MAX_W memory with a synchronous write port and a registered read port. Instantiated twice; the top does the bank-select muxing.
- base multiply is by constant SHEET_W. One combinational multiply in BASE is acceptable; no multicycle is needed.

## Test plan
- Fetch sheet_x=100, sheet_y=10, row=3, width=16 against a RAM model:
  - ram_addr=31833..31848 in cycles T+2..T+17.
  - done at T+19.
  - After swap, pix_col 0..15 return mem[31833..31848], and pix_col 16 returns 0.
- width=200: exactly 128 addresses issued, done at T+131, front_width=128.
- Right-edge clip, sheet_x=2430, width=16: columns 0..10 come from RAM, columns 11..15 read 0, and ram_addr never exceeds row_base+2440.
- Height clip, sheet_y=128, row=5: all columns read 0 and no new ram_addr is driven. width=0 gives done at T+2.
- swap asserted at T+5 during a 16-wide fetch: front is unchanged through T+19, then the exchange lands on the edge after done. start during busy is ignored.
- Reset_n pulsed low at T+8: busy=0 and done=0 immediately, and no done ever follows. After reset, pix_data=0 for all columns.
